mem_port_arbiter: RTL and testbench
===================================

MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 Parameter ADDR_W, default 32, is the address width of all address ports.
REQ-002 Parameter RR_EN, default 1: 1 = round-robin arbitration; 0 = fixed DM-over-IF priority.
REQ-003 Clk  in  1  is the single clock; all state updates on its rising edge.
REQ-004 Reset  in  1  is the asynchronous, active-low reset.
REQ-005 IfReq  in  1  is the instruction-fetch read request, held high until IfGnt.
REQ-006 IfAddr  in  ADDR_W  is the fetch word address, stable while IfReq is high.
REQ-007 IfGnt  out  1  is the fetch grant; the memory command is issued in the same cycle.
REQ-008 IfValid  out  1  flags that IfRData is valid (one-cycle pulse).
REQ-009 IfRData  out  32  is the fetch read data.
REQ-010 DmReq  in  1  is the load/store request, held high until DmGnt.
REQ-011 DmWrite  in  1  selects the access type: 1 = store, 0 = load.
REQ-012 DmAddr  in  ADDR_W  is the data byte address.
REQ-013 DmWData  in  32  is the store data.
REQ-014 DmGnt, DmValid, DmErr  out  1 each  are the data grant, response-valid and misalignment-error flags.
REQ-015 DmRData  out  32  is the load data.
REQ-016 MemAddr  out  ADDR_W  and MemWData  out  32  form the shared memory command.
REQ-017 MemRead, MemWrite  out  1 each  are the shared memory strobes.
REQ-018 MemRData  in  32  is the memory read data, valid one cycle after MemRead.
REQ-019 Stall  out  1  is high when (IfReq & ~IfGnt) | (DmReq & ~DmGnt).

Function
REQ-020 The block SHALL grant at most one requester per cycle; grants are combinational from the current-cycle requests and the priority state.
REQ-021 Single request: the requester SHALL be granted in the same cycle.
REQ-022 Both requesting, RR_EN=1: grant the requester not granted at the last contended grant; RR_EN=0: grant DM.
REQ-023 The LastWin register SHALL update only on cycles where both requests are high.
REQ-024 Granted cycle N: MemAddr = granted address; MemRead = ~DmWrite for DM, 1 for IF; MemWrite = DmWrite for DM.
REQ-025 Ungranted cycles: MemRead = MemWrite = 0, MemAddr = 0, MemWData = 0.
REQ-026 Response tag register {valid, id, write, err} SHALL capture the grant at the edge ending cycle N.
REQ-027 In cycle N+1 the tagged requester's Valid SHALL pulse; RData = MemRData for reads and 0 for stores.
REQ-028 Back-to-back grants in consecutive cycles SHALL be supported: throughput of one access per cycle, fixed latency of 1 cycle.
REQ-029 DM access with DmAddr[1:0] != 0: DmGnt = 1 and no memory strobe is issued; cycle N+1 gives DmValid = 1, DmErr = 1, DmRData = 0.
REQ-030 DmErr SHALL be 0 on every other cycle.
REQ-031 IfAddr[1:0] SHALL be ignored (word fetch).
REQ-032 A requester holding Req after its grant SHALL be treated as a new request.
REQ-033 IfValid and DmValid SHALL never both be high in the same cycle.

Reset
REQ-034 While Reset = 0, all outputs SHALL be 0, the tag register SHALL be invalid and LastWin = IF, so the first contention goes to DM.
REQ-035 Reset asserted mid-access SHALL drop the outstanding response; no Valid pulse follows deassertion.
REQ-036 Grants SHALL resume in the first cycle after Reset deasserts.

Structure
REQ-037 Shared package mips_pkg SHALL hold the requester-ID constants REQ_IF = 0 and REQ_DM = 1, and the response-tag struct typedef.
REQ-038 Grant logic SHALL live in sub-module rr_arbiter2 (2-way, RR_EN-configurable, LastWin register); tag pipeline, muxing and error check stay in the top level.

Verification
REQ-039 Scenario: IfReq alone, IfAddr = 0x40, MemRData = 0x8C020004 -> IfGnt and MemRead in cycle 0; IfValid with IfRData = 0x8C020004 in cycle 1.
REQ-040 Scenario: both requesting from reset for 4 cycles, RR_EN = 1 -> grant order DM, IF, DM, IF; Stall high every cycle.
REQ-041 Scenario: same stimulus, RR_EN = 0 -> DM granted all 4 cycles; IfGnt stays 0; Stall = 1.
REQ-042 Scenario: store DmAddr = 0x100, DmWData = 0xDEADBEEF -> MemWrite = 1 and MemAddr = 0x100 in cycle 0; DmValid = 1, DmRData = 0 in cycle 1.
REQ-043 Scenario: load DmAddr = 0x102 -> no MemRead/MemWrite; cycle 1 gives DmValid = 1, DmErr = 1.
REQ-044 Scenario: IF granted, Reset pulsed low during the next cycle -> no IfValid after reset; the next contention is granted to DM.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared definitions for the memory port arbiter: requester IDs, response tag
// layout and small decode helpers.
package mips_pkg;

  // Requester identifiers, also used as bit indices into request/grant vectors
  localparam logic REQ_IF = 1'b0;
  localparam logic REQ_DM = 1'b1;

  // Response tag captured at the end of a granted cycle
  typedef struct packed {
    logic valid;
    logic id;
    logic write;
    logic err;
  } rspTag_t;

  localparam rspTag_t TAG_IDLE = '{valid: 1'b0, id: REQ_IF, write: 1'b0, err: 1'b0};

  // A data access is misaligned when either byte-offset bit is set
  function automatic logic isMisaligned(input logic [1:0] lowBits);
    return (lowBits != 2'b00);
  endfunction

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way grant logic (IF vs DM). Grants are combinational from the current
// requests; the LastWin register remembers who won the last contended cycle.
module rr_arbiter2 import mips_pkg::*; #(
  parameter bit RR_EN = 1'b1
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic [1:0] req,
  output logic [1:0] gnt
);

  logic lastWin_r;
  logic contendWinner_s;

  // Decide who wins when both requesters ask in the same cycle
  always_comb begin
    contendWinner_s = REQ_DM;
    if (RR_EN) begin
      contendWinner_s = (lastWin_r == REQ_IF) ? REQ_DM : REQ_IF;
    end else begin
      contendWinner_s = REQ_DM;
    end
  end

  // One-hot grant; bit 0 is IF, bit 1 is DM
  always_comb begin
    gnt = 2'b00;
    case (req)
      2'b01:   gnt = 2'b01;
      2'b10:   gnt = 2'b10;
      2'b11:   gnt = (contendWinner_s == REQ_DM) ? 2'b10 : 2'b01;
      default: gnt = 2'b00;
    endcase
  end

  // Track the winner of contended cycles only; reset leaves IF as last winner
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      lastWin_r <= REQ_IF;
    end else if (req == 2'b11) begin
      lastWin_r <= contendWinner_s;
    end else begin
      lastWin_r <= lastWin_r;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-cycle memory port between instruction fetch and data
// accesses. The command goes out in the grant cycle; the response returns
// exactly one cycle later, steered by a registered tag.
module mem_port_arbiter import mips_pkg::*; #(
  parameter int unsigned ADDR_W = 32'd32,
  parameter bit          RR_EN  = 1'b1
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              IfReq,
  input  logic [ADDR_W-1:0] IfAddr,
  output logic              IfGnt,
  output logic              IfValid,
  output logic [31:0]       IfRData,
  input  logic              DmReq,
  input  logic              DmWrite,
  input  logic [ADDR_W-1:0] DmAddr,
  input  logic [31:0]       DmWData,
  output logic              DmGnt,
  output logic              DmValid,
  output logic              DmErr,
  output logic [31:0]       DmRData,
  output logic [ADDR_W-1:0] MemAddr,
  output logic [31:0]       MemWData,
  output logic              MemRead,
  output logic              MemWrite,
  input  logic [31:0]       MemRData,
  output logic              Stall
);

  // Fetches are word accesses: the byte offset is dropped from the address
  localparam logic [ADDR_W-1:0] WORD_MASK = ~{{(ADDR_W-2){1'b0}}, 2'b11};

  logic [1:0] reqVec_s;
  logic [1:0] gnt_s;
  logic       dmMis_s;
  rspTag_t    tag_r;

  // Requests are masked while in reset so every output stays low
  always_comb begin
    reqVec_s         = 2'b00;
    reqVec_s[REQ_IF] = IfReq & Reset;
    reqVec_s[REQ_DM] = DmReq & Reset;
  end

  rr_arbiter2 #(
    .RR_EN (RR_EN)
  ) u_arb (
    .Clk   (Clk),
    .Reset (Reset),
    .req   (reqVec_s),
    .gnt   (gnt_s)
  );

  // Grant outputs, misalignment check and stall indication
  always_comb begin
    IfGnt   = gnt_s[REQ_IF];
    DmGnt   = gnt_s[REQ_DM];
    dmMis_s = isMisaligned(DmAddr[1:0]);
    Stall   = (reqVec_s[REQ_IF] & ~gnt_s[REQ_IF]) | (reqVec_s[REQ_DM] & ~gnt_s[REQ_DM]);
  end

  // Drive the shared memory command for the granted requester
  always_comb begin
    MemAddr  = {ADDR_W{1'b0}};
    MemWData = 32'h0000_0000;
    MemRead  = 1'b0;
    MemWrite = 1'b0;
    if (gnt_s[REQ_IF]) begin
      MemAddr = IfAddr & WORD_MASK;
      MemRead = 1'b1;
    end else if (gnt_s[REQ_DM] && !dmMis_s) begin
      MemAddr  = DmAddr;
      MemRead  = ~DmWrite;
      MemWrite = DmWrite;
      MemWData = DmWrite ? DmWData : 32'h0000_0000;
    end else begin
      MemAddr  = {ADDR_W{1'b0}};
      MemWData = 32'h0000_0000;
      MemRead  = 1'b0;
      MemWrite = 1'b0;
    end
  end

  // Capture who was granted so the response can be steered next cycle
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      tag_r <= TAG_IDLE;
    end else begin
      tag_r.valid <= gnt_s[REQ_IF] | gnt_s[REQ_DM];
      tag_r.id    <= gnt_s[REQ_DM] ? REQ_DM : REQ_IF;
      tag_r.write <= gnt_s[REQ_DM] & DmWrite;
      tag_r.err   <= gnt_s[REQ_DM] & dmMis_s;
    end
  end

  // Steer the response; stores and errored accesses return zero data
  always_comb begin
    IfValid = tag_r.valid & (tag_r.id == REQ_IF);
    DmValid = tag_r.valid & (tag_r.id == REQ_DM);
    DmErr   = tag_r.valid & (tag_r.id == REQ_DM) & tag_r.err;
    if (IfValid) begin
      IfRData = MemRData;
    end else begin
      IfRData = 32'h0000_0000;
    end
    if (DmValid && !tag_r.write && !tag_r.err) begin
      DmRData = MemRData;
    end else begin
      DmRData = 32'h0000_0000;
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: a round-robin instance is checked
// cycle by cycle against a behavioural model; a fixed-priority instance sees
// the same stimulus and is checked against the DM-first rule.
module tb_mem_port_arbiter;

  localparam int AW     = 32;
  localparam int W_NONE = 0;
  localparam int W_IF   = 1;
  localparam int W_DM   = 2;

  logic          Clk = 1'b0;
  logic          Reset = 1'b0;
  logic          IfReq = 1'b0;
  logic [AW-1:0] IfAddr = '0;
  logic          DmReq = 1'b0;
  logic          DmWrite = 1'b0;
  logic [AW-1:0] DmAddr = '0;
  logic [31:0]   DmWData = '0;
  logic [31:0]   MemRData = '0;

  logic          IfGnt, IfValid, DmGnt, DmValid, DmErr, MemRead, MemWrite, Stall;
  logic [31:0]   IfRData, DmRData, MemWData;
  logic [AW-1:0] MemAddr;

  logic          fxIfGnt, fxIfValid, fxDmGnt, fxDmValid, fxDmErr, fxMemRead, fxMemWrite, fxStall;
  logic [31:0]   fxIfRData, fxDmRData, fxMemWData;
  logic [AW-1:0] fxMemAddr;

  mem_port_arbiter #(.ADDR_W(AW), .RR_EN(1'b1)) u_rr (
    .Clk(Clk), .Reset(Reset),
    .IfReq(IfReq), .IfAddr(IfAddr), .IfGnt(IfGnt), .IfValid(IfValid), .IfRData(IfRData),
    .DmReq(DmReq), .DmWrite(DmWrite), .DmAddr(DmAddr), .DmWData(DmWData),
    .DmGnt(DmGnt), .DmValid(DmValid), .DmErr(DmErr), .DmRData(DmRData),
    .MemAddr(MemAddr), .MemWData(MemWData), .MemRead(MemRead), .MemWrite(MemWrite),
    .MemRData(MemRData), .Stall(Stall)
  );

  mem_port_arbiter #(.ADDR_W(AW), .RR_EN(1'b0)) u_fx (
    .Clk(Clk), .Reset(Reset),
    .IfReq(IfReq), .IfAddr(IfAddr), .IfGnt(fxIfGnt), .IfValid(fxIfValid), .IfRData(fxIfRData),
    .DmReq(DmReq), .DmWrite(DmWrite), .DmAddr(DmAddr), .DmWData(DmWData),
    .DmGnt(fxDmGnt), .DmValid(fxDmValid), .DmErr(fxDmErr), .DmRData(fxDmRData),
    .MemAddr(fxMemAddr), .MemWData(fxMemWData), .MemRead(fxMemRead), .MemWrite(fxMemWrite),
    .MemRData(MemRData), .Stall(fxStall)
  );

  always #5 Clk = ~Clk;

  typedef struct {
    bit          inReset;
    bit          ifGnt;
    bit          dmGnt;
    bit          memRead;
    bit          memWrite;
    bit          stall;
    bit          chkAddr;
    bit          chkWData;
    logic [31:0] memAddr;
    logic [31:0] memWData;
  } cmd_t;

  typedef struct {
    int          dueCyc;
    bit          isDm;
    bit          err;
    logic [31:0] data;
  } rsp_t;

  cmd_t        cmdQ[$];
  rsp_t        rspQ[$];
  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  int          monCyc = 0;
  bit          lastDm = 1'b0;
  logic [31:0] nextRData = 32'h0;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  // One active cycle: apply inputs, run the reference model, queue expectations
  task automatic driveCycle(input bit ir, input logic [31:0] ia, input bit dr, input bit dw,
                            input logic [31:0] da, input logic [31:0] dwd,
                            input logic [31:0] rdNext, output int winner);
    cmd_t c;
    rsp_t r;
    bit   mis;
    @(posedge Clk);
    #1;
    cyc++;
    Reset    = 1'b1;
    IfReq    = ir;
    IfAddr   = ia;
    DmReq    = dr;
    DmWrite  = dw;
    DmAddr   = da;
    DmWData  = dwd;
    MemRData = nextRData;
    nextRData = rdNext;
    winner = W_NONE;
    if (ir && dr) begin
      winner = lastDm ? W_IF : W_DM;
      lastDm = (winner == W_DM);
    end else if (ir) begin
      winner = W_IF;
    end else if (dr) begin
      winner = W_DM;
    end
    mis = (da % 4) != 0;
    c.inReset  = 1'b0;
    c.ifGnt    = (winner == W_IF);
    c.dmGnt    = (winner == W_DM);
    c.memRead  = 1'b0;
    c.memWrite = 1'b0;
    c.memAddr  = 32'h0;
    c.memWData = 32'h0;
    c.chkAddr  = 1'b1;
    c.chkWData = 1'b1;
    if (winner == W_IF) begin
      c.memRead  = 1'b1;
      c.memAddr  = ia - (ia % 4);
      c.chkWData = 1'b0;
    end else if (winner == W_DM && mis) begin
      c.chkAddr  = 1'b0;
      c.chkWData = 1'b0;
    end else if (winner == W_DM) begin
      c.memAddr = da;
      if (dw) begin
        c.memWrite = 1'b1;
        c.memWData = dwd;
      end else begin
        c.memRead  = 1'b1;
        c.chkWData = 1'b0;
      end
    end
    c.stall = (ir && winner != W_IF) || (dr && winner != W_DM);
    cmdQ.push_back(c);
    if (winner != W_NONE) begin
      r.dueCyc = cyc + 1;
      r.isDm   = (winner == W_DM);
      r.err    = r.isDm && mis;
      r.data   = 32'h0;
      if (winner == W_IF || (!dw && !mis)) r.data = rdNext;
      rspQ.push_back(r);
    end
  endtask

  // One cycle held in reset: every output must be low, pending responses vanish
  task automatic resetCycle(input bit ir, input bit dr);
    cmd_t c;
    @(posedge Clk);
    #1;
    cyc++;
    Reset    = 1'b0;
    IfReq    = ir;
    DmReq    = dr;
    IfAddr   = $urandom;
    DmAddr   = $urandom;
    DmWrite  = 1'($urandom_range(0, 1));
    DmWData  = $urandom;
    MemRData = $urandom;
    rspQ.delete();
    lastDm   = 1'b0;
    c.inReset  = 1'b1;
    c.ifGnt    = 1'b0;
    c.dmGnt    = 1'b0;
    c.memRead  = 1'b0;
    c.memWrite = 1'b0;
    c.stall    = 1'b0;
    c.chkAddr  = 1'b1;
    c.chkWData = 1'b1;
    c.memAddr  = 32'h0;
    c.memWData = 32'h0;
    cmdQ.push_back(c);
  endtask

  // Monitor: compare every cycle's outputs against queued expectations
  always @(negedge Clk) begin : monitor
    cmd_t        c;
    rsp_t        r;
    bit          eIf, eDm, eErr;
    logic [31:0] eData;
    if (cmdQ.size() != 0) begin
      c = cmdQ.pop_front();
      monCyc++;
      chk("IfGnt", {31'b0, IfGnt}, {31'b0, c.ifGnt});
      chk("DmGnt", {31'b0, DmGnt}, {31'b0, c.dmGnt});
      chk("MemRead", {31'b0, MemRead}, {31'b0, c.memRead});
      chk("MemWrite", {31'b0, MemWrite}, {31'b0, c.memWrite});
      chk("Stall", {31'b0, Stall}, {31'b0, c.stall});
      if (c.chkAddr) chk("MemAddr", MemAddr, c.memAddr);
      if (c.chkWData) chk("MemWData", MemWData, c.memWData);
      eIf = 1'b0; eDm = 1'b0; eErr = 1'b0; eData = 32'h0;
      if (rspQ.size() != 0 && rspQ[0].dueCyc == monCyc) begin
        r     = rspQ.pop_front();
        eIf   = !r.isDm;
        eDm   = r.isDm;
        eErr  = r.err;
        eData = r.data;
      end
      chk("IfValid", {31'b0, IfValid}, {31'b0, eIf});
      chk("DmValid", {31'b0, DmValid}, {31'b0, eDm});
      chk("DmErr", {31'b0, DmErr}, {31'b0, eErr});
      if (eIf) chk("IfRData", IfRData, eData);
      if (eDm) chk("DmRData", DmRData, eData);
      if (c.inReset) begin
        chk("reset_IfRData", IfRData, 32'h0);
        chk("reset_DmRData", DmRData, 32'h0);
      end
      chk("fx_DmGnt", {31'b0, fxDmGnt}, {31'b0, DmReq & Reset});
      chk("fx_IfGnt", {31'b0, fxIfGnt}, {31'b0, IfReq & ~DmReq & Reset});
      chk("fx_Stall", {31'b0, fxStall}, {31'b0, IfReq & DmReq & Reset});
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: actual timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    int          w;
    bit          ifP, dmP, dw;
    logic [31:0] ia, da, dwd;
    ifP = 1'b0; dmP = 1'b0; dw = 1'b0;
    ia = 32'h0; da = 32'h0; dwd = 32'h0;

    // Reset with both requests high: outputs must stay low
    resetCycle(1'b1, 1'b1);
    resetCycle(1'b1, 1'b1);

    // Contention straight out of reset: DM, IF, DM, IF; fixed instance always DM
    for (int i = 0; i < 4; i++) begin
      driveCycle(1'b1, 32'h1000 + 32'(i) * 32'd4, 1'b1, 1'b0, 32'h2000, 32'h0, $urandom, w);
      @(negedge Clk);
      chk("rr_order_DmGnt", {31'b0, DmGnt}, (i % 2 == 0) ? 32'd1 : 32'd0);
      chk("rr_order_IfGnt", {31'b0, IfGnt}, (i % 2 == 0) ? 32'd0 : 32'd1);
      chk("rr_order_Stall", {31'b0, Stall}, 32'd1);
      chk("fx_order_DmGnt", {31'b0, fxDmGnt}, 32'd1);
      chk("fx_order_IfGnt", {31'b0, fxIfGnt}, 32'd0);
      chk("fx_order_Stall", {31'b0, fxStall}, 32'd1);
    end

    // Lone fetch of 0x40 returning 0x8C020004
    driveCycle(1'b1, 32'h40, 1'b0, 1'b0, 32'h0, 32'h0, 32'h8C02_0004, w);
    @(negedge Clk);
    chk("fetch_IfGnt", {31'b0, IfGnt}, 32'd1);
    chk("fetch_MemRead", {31'b0, MemRead}, 32'd1);
    chk("fetch_MemAddr", MemAddr, 32'h40);
    driveCycle(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, $urandom, w);
    @(negedge Clk);
    chk("fetch_IfValid", {31'b0, IfValid}, 32'd1);
    chk("fetch_IfRData", IfRData, 32'h8C02_0004);

    // Store of 0xDEADBEEF to 0x100
    driveCycle(1'b0, 32'h0, 1'b1, 1'b1, 32'h100, 32'hDEAD_BEEF, $urandom, w);
    @(negedge Clk);
    chk("store_MemWrite", {31'b0, MemWrite}, 32'd1);
    chk("store_MemAddr", MemAddr, 32'h100);
    chk("store_MemWData", MemWData, 32'hDEAD_BEEF);
    driveCycle(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, $urandom, w);
    @(negedge Clk);
    chk("store_DmValid", {31'b0, DmValid}, 32'd1);
    chk("store_DmRData", DmRData, 32'h0);
    chk("store_DmErr", {31'b0, DmErr}, 32'd0);

    // Misaligned load from 0x102
    driveCycle(1'b0, 32'h0, 1'b1, 1'b0, 32'h102, 32'h0, $urandom, w);
    @(negedge Clk);
    chk("mis_DmGnt", {31'b0, DmGnt}, 32'd1);
    chk("mis_MemRead", {31'b0, MemRead}, 32'd0);
    chk("mis_MemWrite", {31'b0, MemWrite}, 32'd0);
    driveCycle(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, $urandom, w);
    @(negedge Clk);
    chk("mis_DmValid", {31'b0, DmValid}, 32'd1);
    chk("mis_DmErr", {31'b0, DmErr}, 32'd1);
    chk("mis_DmRData", DmRData, 32'h0);

    // Reset during an IF response: response dropped, next contention to DM
    driveCycle(1'b1, 32'h300, 1'b1, 1'b0, 32'h400, 32'h0, $urandom, w);
    driveCycle(1'b1, 32'h80, 1'b0, 1'b0, 32'h0, 32'h0, $urandom, w);
    resetCycle(1'b0, 1'b0);
    @(negedge Clk);
    chk("rst_IfValid", {31'b0, IfValid}, 32'd0);
    driveCycle(1'b1, 32'h500, 1'b1, 1'b0, 32'h600, 32'h0, $urandom, w);
    @(negedge Clk);
    chk("rst_next_DmGnt", {31'b0, DmGnt}, 32'd1);
    chk("rst_next_IfGnt", {31'b0, IfGnt}, 32'd0);

    // Randomized traffic with held requests and occasional resets
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 59) == 0) begin
        resetCycle(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        ifP = 1'b0;
        dmP = 1'b0;
      end else begin
        if (!ifP) begin
          ifP = ($urandom_range(0, 3) != 0);
          ia  = $urandom;
        end
        if (!dmP) begin
          dmP = ($urandom_range(0, 3) != 0);
          dw  = 1'($urandom_range(0, 1));
          da  = $urandom;
          if ($urandom_range(0, 3) != 0) da = da - (da % 4);
          dwd = $urandom;
        end
        driveCycle(ifP, ia, dmP, dw, da, dwd, $urandom, w);
        if (w == W_IF) ifP = 1'b0;
        if (w == W_DM) dmP = 1'b0;
      end
    end

    // Drain outstanding responses
    driveCycle(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, $urandom, w);
    driveCycle(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, $urandom, w);
    @(negedge Clk);
    #1;
    chk("rsp_drained", 32'(rspQ.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
